// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS serial deserializer: FSM state encoding
// and the default payload width.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/cmos_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to 1 so
// the line reads as idle until real data has propagated through.
module cmos_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cmos_deser.sv
// Strobe-driven serial-to-parallel receiver: start bit, DATA_W payload bits
// LSB first, one stop bit, with a single-entry valid/ready output register.
module cmos_deser
  import cmos_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              sample_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              din_s;
  logic              complete;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  cmos_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (din_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    complete     = 1'b0;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (!din_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {din_s, shift_q[DATA_W-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
          if (din_s) begin
            complete = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A frame may land only if the slot is empty or being drained this cycle.
    if (complete) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cmos_deser.sv
// Directed bench for cmos_deser: nominal frame, bad stop, backpressure,
// simultaneous handshake, strobe gaps and reset in the middle of a frame.
module tb_cmos_deser;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       sample_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;

  int total;
  int bad;

  cmos_deser #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sample_en (sample_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    din       = 1'b1;
    sample_en = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Period 1 strobes every cycle; period 4 strobes on the last cycle of each
  // bit and drives the inverted bit on cycles the strobe cannot see.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int period);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (period == 1) begin
        din       = bits[i];
        sample_en = 1'b1;
        tick();
      end else begin
        for (int c = 0; c < period; c++) begin
          din       = (c == 1 || c == 3 || i == 9) ? bits[i] : ~bits[i];
          sample_en = (c == period - 1);
          tick();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din        = 1'b1;
    sample_en  = 1'b0;
    dout_ready = 1'b0;
    #12;
    total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    send_frame(8'hA5, 1'b1, 1);
    idle_cycles(1);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL nominal_early_valid got=%b exp=0", dout_valid); end
    idle_cycles(1);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL nominal_valid got=%b exp=1", dout_valid); end
    total++; if (dout !== 8'hA5) begin bad++; $display("[TB] FAIL nominal_dout got=%h exp=a5", dout); end
    dout_ready = 1'b1;
    idle_cycles(1);
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL nominal_drain_valid got=%b exp=0", dout_valid); end
    total++; if (dout !== 8'hA5) begin bad++; $display("[TB] FAIL nominal_drain_dout got=%h exp=a5", dout); end
  endtask

  task automatic test_bad_stop();
    send_frame(8'h3C, 1'b0, 1);
    idle_cycles(1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL badstop_early got=%b exp=0", frame_err); end
    idle_cycles(1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL badstop_pulse got=%b exp=1", frame_err); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL badstop_valid got=%b exp=0", dout_valid); end
    idle_cycles(1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL badstop_width got=%b exp=0", frame_err); end
    total++; if (dout !== 8'hA5) begin bad++; $display("[TB] FAIL badstop_dout got=%h exp=a5", dout); end
  endtask

  task automatic test_backpressure();
    send_frame(8'h11, 1'b1, 1);
    idle_cycles(2);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_first_valid got=%b exp=1", dout_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL bp_first_overrun got=%b exp=0", overrun); end
    send_frame(8'h22, 1'b1, 1);
    idle_cycles(2);
    total++; if (dout !== 8'h11) begin bad++; $display("[TB] FAIL bp_dout got=%h exp=11", dout); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL bp_overrun got=%b exp=1", overrun); end
    dout_ready = 1'b1;
    idle_cycles(1);
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain_valid got=%b exp=0", dout_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL bp_sticky got=%b exp=1", overrun); end
    idle_cycles(2);
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL bp_sticky_later got=%b exp=1", overrun); end
  endtask

  task automatic test_back_to_back();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_reset_overrun got=%b exp=0", overrun); end
    tick();
    send_frame(8'h11, 1'b1, 1);
    idle_cycles(2);
    total++; if (dout !== 8'h11) begin bad++; $display("[TB] FAIL b2b_first_dout got=%h exp=11", dout); end
    send_frame(8'h22, 1'b1, 1);
    idle_cycles(1);
    dout_ready = 1'b1;
    idle_cycles(1);
    dout_ready = 1'b0;
    total++; if (dout !== 8'h22) begin bad++; $display("[TB] FAIL b2b_dout got=%h exp=22", dout); end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid got=%b exp=1", dout_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun got=%b exp=0", overrun); end
    dout_ready = 1'b1;
    idle_cycles(1);
    dout_ready = 1'b0;
  endtask

  task automatic test_strobe_gaps();
    send_frame(8'hC3, 1'b1, 4);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid got=%b exp=1", dout_valid); end
    total++; if (dout !== 8'hC3) begin bad++; $display("[TB] FAIL gap_dout got=%h exp=c3", dout); end
    sample_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] partial;
    partial = 7'b1010110;
    for (int i = 0; i < 7; i++) begin
      din       = partial[i];
      sample_en = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL midrst_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b exp=0", dout_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_frame_err got=%b exp=0", frame_err); end
    din = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    idle_cycles(3);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_no_update got=%b exp=0", dout_valid); end
    send_frame(8'h5A, 1'b1, 1);
    idle_cycles(2);
    total++; if (dout !== 8'h5A) begin bad++; $display("[TB] FAIL midrst_next_dout got=%h exp=5a", dout); end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_next_valid got=%b exp=1", dout_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_next_err got=%b exp=0", frame_err); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_nominal();
    test_bad_stop();
    test_backpressure();
    test_back_to_back();
    test_strobe_gaps();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmos_deser.md
CMOS_DESER -- requirements
Module: cmos_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload bits per frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on din, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, 1 bit: asynchronous serial line, the output of the upstream CMOS inverter stage; idles high.
REQ-006 SHALL have port sample_en, input, 1 bit: bit-sample strobe; synchronized din is evaluated only on cycles with sample_en=1.
REQ-007 SHALL have port dout, output, DATA_W bits: last accepted payload.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds unconsumed data.
REQ-009 SHALL have port dout_ready, input, 1 bit: consumer accepts dout when dout_valid=1 and dout_ready=1 in the same cycle.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag for a frame dropped because the output was full; cleared only by reset.

Function
REQ-012 SHALL pass din through SYNC_STAGES flops before any use; din-to-FSM latency SHALL be SYNC_STAGES cycles.
REQ-013 SHALL implement FSM states IDLE, DATA and STOP.
REQ-014 IDLE: on sample_en=1 with synced din=0 (start bit), SHALL go to DATA and clear the bit counter to 0; otherwise stay in IDLE.
REQ-015 DATA: on each sample_en=1, SHALL shift synced din into the shift register LSB-first and increment the counter; on the sample where counter=DATA_W-1, SHALL go to STOP.
REQ-016 STOP, sample_en=1, synced din=1: SHALL complete the frame and go to IDLE.
REQ-017 STOP, sample_en=1, synced din=0: SHALL pulse frame_err for exactly 1 cycle, discard the payload, leave dout and dout_valid unchanged, and go to IDLE.
REQ-018 Cycles with sample_en=0 SHALL leave the state, counter and shift register unchanged.
REQ-019 Completion with output empty (dout_valid=0): SHALL load dout and set dout_valid on the next clock edge, i.e. 1 cycle after the stop-bit sample.
REQ-020 Completion in the same cycle as a handshake (dout_valid=1, dout_ready=1): SHALL load the new payload and keep dout_valid=1, with no overrun.
REQ-021 Completion with dout_valid=1 and dout_ready=0: SHALL keep the old dout, drop the new payload, and set overrun.
REQ-022 A handshake with no completing frame SHALL clear dout_valid on the next edge; dout SHALL hold its value.
REQ-023 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-024 The counter SHALL be $clog2(DATA_W) bits wide and SHALL never exceed DATA_W-1.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, counter 0, shift register 0, dout 0, dout_valid 0, frame_err 0, overrun 0, and all synchronizer flops to 1 (line idle).
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no frame_err and no dout update.
REQ-027 After reset deassertion, the first start bit SHALL be recognizable only once synchronized, i.e. SYNC_STAGES cycles after din falls.

Structure
REQ-028 A shared package cmos_pkg SHALL hold the state encoding constants (IDLE=2'd0, DATA=2'd1, STOP=2'd2) and the default DATA_W.
REQ-029 The synchronizer SHALL be a separate sub-module cmos_sync: parameter SYNC_STAGES, reset value 1, ports clk, rst_n, d, q.
REQ-030 The deserializer FSM, counter, shift register and output register SHALL reside in cmos_deser.

Verification
REQ-031 Nominal frame: sample_en=1 every cycle, frame 0, 1,0,1,0,0,1,0,1 (LSB first), 1 -> dout=8'hA5, dout_valid=1 one cycle after the stop sample; dout_ready=1 then clears dout_valid.
REQ-032 Bad stop: frame 8'h3C with stop bit=0 -> frame_err high for exactly 1 cycle, dout_valid stays 0, FSM back in IDLE.
REQ-033 Backpressure: frames 8'h11 then 8'h22 with dout_ready=0 -> dout=8'h11, overrun=1; asserting dout_ready then clears dout_valid while overrun stays 1.
REQ-034 Simultaneous handshake: dout_ready=1 in the completion cycle of 8'h22 while 8'h11 is held -> dout=8'h22, dout_valid=1, overrun=0.
REQ-035 Strobe gaps: sample_en=1 only every 4th cycle, frame 8'hC3 -> dout=8'hC3; din toggling on non-strobe cycles has no effect.
REQ-036 Reset mid-frame: rst_n pulsed low after 4 data bits -> all outputs 0 immediately; the next full frame 8'h5A is received correctly.
